// File: rtl/rsa_pkg.sv
// Shared sizes, sequencer states and latency for the RSA encrypt engine.
package rsa_pkg;

  localparam int DEF_W  = 7;
  localparam int DEF_EW = 7;

  // start-sampling edge to done-high edge, normal path
  localparam int LATENCY = (DEF_EW + 1) * DEF_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    EXP,
    FINISH
  } state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, b < n required.
// load processes a's MSB at once; W-1 further cycles finish the product.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] p
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_r;
  logic [W-1:0]  n_r;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;

  // One Horner step; W+1 bits hold 2*acc and acc+b without overflow since acc, b < n.
  function automatic logic [W-1:0] step(input logic [W-1:0] acc_in, input logic abit,
                                        input logic [W-1:0] bv, input logic [W-1:0] nv);
    logic [W:0] t;
    t = {acc_in, 1'b0};
    if (t >= {1'b0, nv}) t = t - {1'b0, nv};
    if (abit) t = t + {1'b0, bv};
    if (t >= {1'b0, nv}) t = t - {1'b0, nv};
    return t[W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh <= '0;
      b_r  <= '0;
      n_r  <= '0;
      acc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      acc  <= step('0, a[W-1], b, n);
      a_sh <= {a[W-2:0], 1'b0};
      b_r  <= b;
      n_r  <= n;
      cnt  <= CW'(W - 1);
      done <= 1'b0;
    end else if (cnt != '0) begin
      acc  <= step(acc, a_sh[W-1], b_r, n_r);
      a_sh <= {a_sh[W-2:0], 1'b0};
      cnt  <= cnt - 1'b1;
      done <= (cnt == CW'(1));
    end else begin
      done <= 1'b0;
    end
  end

  assign busy = (cnt != '0);
  assign p    = acc;

endmodule

// File: rtl/rsa_encrypt_seq.sv
// RSA encryption C = M^e mod n, right-to-left square-and-multiply with a
// fixed (EW+1)*W+1 cycle schedule independent of e and M.
module rsa_encrypt_seq
  import rsa_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int EW = DEF_EW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  M,
  input  logic [EW-1:0] e,
  input  logic [W-1:0]  n,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  encrypted_C,
  output logic          err
);

  localparam int CW = $clog2(W);
  localparam int BW = (EW > 1) ? $clog2(EW) : 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(W - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(EW - 1);

  state_t state, state_next;

  logic [EW-1:0] e_r;
  logic [W-1:0]  n_r, res, base, res_next, base_next;
  logic [CW-1:0] cyc;
  logic [BW-1:0] bit_idx;
  logic          bad, step_end, last_bit, accept;
  logic          mul_load, sq_load;
  logic [W-1:0]  mul_a, mul_b, mul_n, mul_p, sq_p;
  logic          mul_busy, mul_done, sq_busy, sq_done;

  assign step_end = (cyc == LAST_CYC);
  assign last_bit = (bit_idx == LAST_BIT);
  assign accept   = (state == IDLE) && start;

  always_comb begin
    state_next = state;
    res_next   = res;
    base_next  = base;
    mul_load   = 1'b0;
    sq_load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (n < W'(2)) ? FINISH : REDUCE;
          mul_load   = (n >= W'(2));
        end
      end
      REDUCE: begin
        if (step_end) begin
          state_next = EXP;
          res_next   = W'(1);
          base_next  = mul_p;
          mul_load   = 1'b1;
          sq_load    = 1'b1;
        end
      end
      EXP: begin
        if (step_end) begin
          res_next  = e_r[bit_idx] ? mul_p : res;
          base_next = sq_p;
          if (last_bit) begin
            state_next = FINISH;
          end else begin
            mul_load = 1'b1;
            sq_load  = 1'b1;
          end
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Next iteration's operands come straight from the products just finished.
    mul_a = (state == IDLE) ? M : res_next;
    mul_b = (state == IDLE) ? W'(1) : base_next;
    mul_n = (state == IDLE) ? n : n_r;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_r         <= '0;
      n_r         <= '0;
      res         <= '0;
      base        <= '0;
      cyc         <= '0;
      bit_idx     <= '0;
      bad         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      encrypted_C <= '0;
      err         <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (accept) begin
        e_r     <= e;
        n_r     <= n;
        err     <= 1'b0;
        busy    <= 1'b1;
        bad     <= (n < W'(2));
        res     <= '0;
        cyc     <= '0;
        bit_idx <= '0;
      end
      if (state == REDUCE || state == EXP) begin
        cyc <= step_end ? '0 : cyc + 1'b1;
        if (step_end) begin
          res  <= res_next;
          base <= base_next;
          if (state == EXP) bit_idx <= bit_idx + 1'b1;
        end
      end
      if (state == FINISH) begin
        encrypted_C <= res;
        err         <= bad;
        busy        <= 1'b0;
      end
    end
  end

  rsa_modmul #(.W(W)) u_mul (
    .clk(clk), .reset(reset), .load(mul_load),
    .a(mul_a), .b(mul_b), .n(mul_n),
    .busy(mul_busy), .done(mul_done), .p(mul_p)
  );

  rsa_modmul #(.W(W)) u_sq (
    .clk(clk), .reset(reset), .load(sq_load),
    .a(base_next), .b(base_next), .n(n_r),
    .busy(sq_busy), .done(sq_done), .p(sq_p)
  );

  // Sequencing runs off cyc/bit_idx; the multipliers' own status is informational.
  logic unused_mul_status;
  assign unused_mul_status = ^{mul_busy, mul_done, sq_busy, sq_done};

endmodule

// File: tb/tb_rsa_encrypt_seq.sv
// Directed and swept checks of rsa_encrypt_seq against a naive pow(M,e,n) model.
module tb_rsa_encrypt_seq;
  import rsa_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [6:0] M, e, n;
  logic       busy, done, err;
  logic [6:0] encrypted_C;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int done_cnt = 0;

  rsa_encrypt_seq dut (
    .clk(clk), .reset(reset), .start(start), .M(M), .e(e), .n(n),
    .busy(busy), .done(done), .encrypted_C(encrypted_C), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && done) overlap++;
    if (done) done_cnt++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_pow(input int m, input int ee, input int nn);
    int r;
    r = 1 % nn;
    for (int i = 0; i < ee; i++) r = (r * (m % nn)) % nn;
    return r;
  endfunction

  // Caller is #1 after an edge; the next edge samples start.
  task automatic run_op(input int m, input int ee, input int nn,
                        output int lat, output int c, output int er);
    start = 1'b1;
    M = m[6:0]; e = ee[6:0]; n = nn[6:0];
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    c = encrypted_C;
    er = err;
  endtask

  int vm[11] = '{4, 5, 40, 33, 9, 126, 2, 127, 3, 2, 3};
  int ve[11] = '{7, 3, 3, 5, 0, 127, 7, 3, 4, 1, 127};
  int vn[11] = '{33, 33, 33, 33, 33, 127, 127, 127, 2, 2, 5};
  int vc[11] = '{16, 26, 13, 0, 1, 126, 1, 0, 1, 0, 2};

  initial begin
    int lat, c, er, dc0, m, ee;
    reset = 1'b1; start = 1'b0; M = '0; e = '0; n = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_c", encrypted_C, 0);
    check_eq("rst_err", err, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, issued back to back: each start lands in the IDLE cycle after done.
    for (int i = 0; i < 11; i++) begin
      run_op(vm[i], ve[i], vn[i], lat, c, er);
      check_eq($sformatf("vec%0d_c", i), c, vc[i]);
      check_eq($sformatf("vec%0d_lat", i), lat, LATENCY);
      check_eq($sformatf("vec%0d_err", i), er, 0);
    end

    run_op(9, 5, 1, lat, c, er);
    check_eq("n1_err", er, 1);
    check_eq("n1_c", c, 0);
    check_eq("n1_lat", lat, 1);
    run_op(9, 5, 0, lat, c, er);
    check_eq("n0_err", er, 1);
    check_eq("n0_lat", lat, 1);
    run_op(5, 3, 33, lat, c, er);
    check_eq("err_clear", er, 0);
    check_eq("after_err_c", c, 26);

    // Starts while busy and during FINISH must be ignored.
    @(posedge clk); #1;
    dc0 = done_cnt;
    start = 1'b1; M = 7'd4; e = 7'd7; n = 7'd33;
    @(posedge clk); #1;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      start = (lat < 10) || (lat == LATENCY - 1);
      M = 7'($urandom); e = 7'($urandom); n = 7'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check_eq("busy_start_c", encrypted_C, 16);
    check_eq("busy_start_lat", lat, LATENCY);
    @(posedge clk); #1;
    check_eq("finish_start_ignored", busy, 0);
    check_eq("single_done", done_cnt - dc0, 1);

    // Reset mid-operation clears the previous result and aborts silently.
    start = 1'b1; M = 7'd4; e = 7'd7; n = 7'd33;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_c", encrypted_C, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("midrst_no_done", done, 0);
    run_op(4, 7, 33, lat, c, er);
    check_eq("postrst_c", c, 16);
    check_eq("postrst_lat", lat, LATENCY);

    for (int nn = 2; nn < 128; nn++) begin
      m = $urandom_range(0, 127);
      ee = $urandom_range(0, 127);
      run_op(m, ee, nn, lat, c, er);
      check_eq($sformatf("sweep_n%0d_m%0d_e%0d", nn, m, ee), c, ref_pow(m, ee, nn));
      check_eq($sformatf("sweep_n%0d_lat", nn), lat, LATENCY);
    end

    check_eq("busy_done_excl", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
